// File: rtl/mem_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_pkg
// Description : Shared definitions for the host request sequencer and the
//               memory controller: controller command encodings, sequencer
//               state encodings and address field widths.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_pkg;

    // Address split: row is the upper field, column the lower field.
    localparam int ROW_W = 4;
    localparam int COL_W = 12;

    // Controller command bus encodings.
    typedef enum logic [2:0] {
        CMD_NOP     = 3'b000,
        CMD_ACT     = 3'b001,
        CMD_READ    = 3'b010,
        CMD_WRITE   = 3'b011,
        CMD_PRE     = 3'b100,
        CMD_REFRESH = 3'b101
    } cmd_t;

    // Sequencer FSM state encodings.
    typedef logic [2:0] seq_state_t;
    localparam seq_state_t ST_IDLE    = 3'd0;
    localparam seq_state_t ST_ISSUE   = 3'd1;
    localparam seq_state_t ST_WAIT_RD = 3'd2;
    localparam seq_state_t ST_CAPTURE = 3'd3;
    localparam seq_state_t ST_WAIT_WR = 3'd4;
    localparam seq_state_t ST_RESP    = 3'd5;

endpackage
`default_nettype wire

// File: rtl/mem_req_fifo.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_fifo
// Description : Synchronous FIFO holding host requests {rdnwr, addr, wdata}.
//               Read data is the head entry (first-word fall-through).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               push, wdata       - enqueue (ignored when full)
//               pop, rdata        - dequeue head (ignored when empty)
//               full, empty,count - occupancy status from registered count
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 49
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [WIDTH-1:0]             wdata,
    input  logic                         pop,
    output logic [WIDTH-1:0]             rdata,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // DEPTH is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : mem_req_sequencer
// Description : Buffers host read/write requests and issues them one at a
//               time to the memory controller, holding the command pins
//               stable until completion (or timeout), then returns an
//               in-order response.
// Ports       : clk, rst                        - clock, sync active-high reset
//               req_valid/ready/rdnwr/addr/wdata - host request channel
//               rsp_valid/ready/rdnwr/rdata/err  - host response channel
//               cmd_n, RDnWR, Addr_in,
//               Data_in_vld, Data_in            - controller command pins
//               command, Data_out               - controller status/read data
// Revision    : 1.0 - initial release
// ============================================================================
module mem_req_sequencer
    import mem_ctrl_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255,
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_rdnwr,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic              rsp_rdnwr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              cmd_n,
    output logic              RDnWR,
    output logic [ADDR_W-1:0] Addr_in,
    output logic              Data_in_vld,
    output logic [DATA_W-1:0] Data_in,
    input  logic [2:0]        command,
    input  logic [DATA_W-1:0] Data_out
);

    localparam int          ENT_W     = 1 + ADDR_W + DATA_W;
    localparam int          CNT_W     = $clog2(DEPTH+1);
    localparam logic [15:0] C_TIMEOUT = 16'(TIMEOUT);

    // Request FIFO
    logic              fifo_push;
    logic              fifo_pop;
    logic [ENT_W-1:0]  fifo_rdata;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count_unused;
    logic              fifo_rd_rdnwr;
    logic [ADDR_W-1:0] fifo_rd_addr;
    logic [DATA_W-1:0] fifo_rd_wdata;

    // Only registered occupancy and reset feed req_ready.
    assign req_ready = !fifo_full && !rst;
    assign fifo_push = req_valid && req_ready;
    assign {fifo_rd_rdnwr, fifo_rd_addr, fifo_rd_wdata} = fifo_rdata;

    mem_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .wdata ({req_rdnwr, req_addr, req_wdata}),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count_unused)
    );

    // Sequencer state
    seq_state_t        state_q, state_d;
    logic [15:0]       tmo_q, tmo_d;
    logic              hold_rdnwr_q, hold_rdnwr_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
    logic              rsp_rdnwr_q, rsp_rdnwr_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic [15:0]       tmo_inc;
    logic              tmo_hit;

    // Saturating wait counter; compared against TIMEOUT before incrementing,
    // so the timeout fires TIMEOUT+1 cycles after ISSUE.
    assign tmo_inc = (tmo_q == 16'hFFFF) ? tmo_q : tmo_q + 16'd1;
    assign tmo_hit = (tmo_q == C_TIMEOUT);

    always_comb begin
        state_d      = state_q;
        tmo_d        = tmo_q;
        hold_rdnwr_d = hold_rdnwr_q;
        hold_addr_d  = hold_addr_q;
        hold_wdata_d = hold_wdata_q;
        rsp_rdnwr_d  = rsp_rdnwr_q;
        rsp_rdata_d  = rsp_rdata_q;
        rsp_err_d    = rsp_err_q;
        fifo_pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop     = 1'b1;
                    hold_rdnwr_d = fifo_rd_rdnwr;
                    hold_addr_d  = fifo_rd_addr;
                    hold_wdata_d = fifo_rd_wdata;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                tmo_d   = '0;
                state_d = hold_rdnwr_q ? ST_WAIT_RD : ST_WAIT_WR;
            end
            ST_WAIT_RD: begin
                tmo_d = tmo_inc;
                if (command == CMD_READ) begin
                    state_d = ST_CAPTURE;
                end else if (tmo_hit) begin
                    rsp_rdnwr_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_CAPTURE: begin
                // Controller's Data_out is registered: valid the cycle after READ.
                rsp_rdnwr_d = 1'b1;
                rsp_rdata_d = Data_out;
                rsp_err_d   = 1'b0;
                state_d     = ST_RESP;
            end
            ST_WAIT_WR: begin
                tmo_d = tmo_inc;
                if (command == CMD_WRITE) begin
                    rsp_rdnwr_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b0;
                    state_d     = ST_RESP;
                end else if (tmo_hit) begin
                    rsp_rdnwr_d = 1'b0;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    state_d     = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            tmo_q        <= '0;
            hold_rdnwr_q <= 1'b1;
            hold_addr_q  <= '0;
            hold_wdata_q <= '0;
            rsp_rdnwr_q  <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_q        <= tmo_d;
            hold_rdnwr_q <= hold_rdnwr_d;
            hold_addr_q  <= hold_addr_d;
            hold_wdata_q <= hold_wdata_d;
            rsp_rdnwr_q  <= rsp_rdnwr_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign cmd_n       = (state_q != ST_ISSUE);
    assign Data_in_vld = (state_q == ST_WAIT_WR);
    assign rsp_valid   = (state_q == ST_RESP);
    assign RDnWR       = hold_rdnwr_q;
    assign Addr_in     = hold_addr_q;
    assign Data_in     = hold_wdata_q;
    assign rsp_rdnwr   = rsp_rdnwr_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_req_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_req_sequencer
// Description : Self-checking bench for mem_req_sequencer with a behavioural
//               controller model and a request-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_req_sequencer;
    import mem_ctrl_pkg::*;

    localparam int TIMEOUT = 255;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_rdnwr;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_rdnwr;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        cmd_n;
    logic        RDnWR;
    logic [15:0] Addr_in;
    logic        Data_in_vld;
    logic [31:0] Data_in;
    logic [2:0]  command;
    logic [31:0] Data_out;

    mem_req_sequencer #(
        .DEPTH   (4),
        .TIMEOUT (TIMEOUT),
        .ADDR_W  (16),
        .DATA_W  (32)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rdnwr   (req_rdnwr),
        .req_addr    (req_addr),
        .req_wdata   (req_wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdnwr   (rsp_rdnwr),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .cmd_n       (cmd_n),
        .RDnWR       (RDnWR),
        .Addr_in     (Addr_in),
        .Data_in_vld (Data_in_vld),
        .Data_in     (Data_in),
        .command     (command),
        .Data_out    (Data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    // Unwritten locations read back as a pattern derived from the address.
    function automatic logic [31:0] dflt(input logic [15:0] a);
        return {~a, a};
    endfunction

    // ---------------- controller model ----------------
    bit          ctrl_dead  = 1'b0;
    bit          ctrl_rand  = 1'b0;
    int          ctrl_delay = 7;
    logic [31:0] ctl_mem [logic [15:0]];

    initial begin : ctrl_model
        bit          pending;
        int          cnt;
        bit          rd_issued;
        logic [31:0] rd_val;
        pending   = 1'b0;
        cnt       = 0;
        rd_issued = 1'b0;
        rd_val    = '0;
        command   = CMD_NOP;
        Data_out  = '0;
        forever begin
            @(posedge clk);
            #2;
            Data_out  = rd_issued ? rd_val : $urandom;
            rd_issued = 1'b0;
            command   = CMD_NOP;
            if (rst || ctrl_dead) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    cnt = cnt - 1;
                    if (cnt == 0) begin
                        pending = 1'b0;
                        if (RDnWR) begin
                            command   = CMD_READ;
                            rd_issued = 1'b1;
                            rd_val    = ctl_mem.exists(Addr_in) ? ctl_mem[Addr_in] : dflt(Addr_in);
                        end else begin
                            command          = CMD_WRITE;
                            ctl_mem[Addr_in] = Data_in;
                        end
                    end
                end
                if (!cmd_n) begin
                    pending = 1'b1;
                    cnt     = ctrl_rand ? int'($urandom_range(1, 8)) : ctrl_delay;
                end
            end
        end
    end

    // ---------------- observation (recording only) ----------------
    int          issue_cnt      = 0;
    int          last_issue_cyc = 0;
    logic [15:0] last_issue_addr = '0;
    int          dvld_cnt       = 0;
    int          wr_vld_cnt     = 0;
    int          unstable       = 0;
    int          last_rise_cyc  = 0;

    initial begin : monitor
        bit          in_flight;
        bit          prev_v;
        logic [15:0] fl_addr;
        logic        fl_rd;
        logic [31:0] fl_wd;
        in_flight = 1'b0;
        prev_v    = 1'b0;
        fl_addr   = '0;
        fl_rd     = 1'b0;
        fl_wd     = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_flight = 1'b0;
            end else if (!cmd_n) begin
                issue_cnt++;
                last_issue_cyc  = cyc;
                last_issue_addr = Addr_in;
                in_flight = 1'b1;
                fl_addr   = Addr_in;
                fl_rd     = RDnWR;
                fl_wd     = Data_in;
            end else if (in_flight && (Addr_in !== fl_addr || RDnWR !== fl_rd ||
                                       (!fl_rd && Data_in !== fl_wd))) begin
                unstable++;
            end
            if (Data_in_vld) dvld_cnt++;
            if (command == CMD_WRITE && Data_in_vld) wr_vld_cnt++;
            if (rsp_valid && !prev_v) last_rise_cyc = cyc;
            prev_v = rsp_valid;
            if (rsp_valid && rsp_ready) in_flight = 1'b0;
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        rd;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_mem [logic [15:0]];

    task automatic model_push(input logic rd, input logic [15:0] a, input logic [31:0] d);
        exp_t e;
        e.rd = rd;
        if (ctrl_dead) begin
            e.err  = 1'b1;
            e.data = '0;
        end else if (rd) begin
            e.err  = 1'b0;
            e.data = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
        end else begin
            e.err    = 1'b0;
            e.data   = '0;
            ref_mem[a] = d;
        end
        exp_q.push_back(e);
    endtask

    // Offer one request until accepted (bounded); acc_cyc is the cycle
    // that starts right after the accepting edge.
    task automatic push_req(input logic rd, input logic [15:0] a, input logic [31:0] d,
                            output bit ok, output int acc_cyc);
        bit s;
        ok      = 1'b0;
        acc_cyc = 0;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_rdnwr = rd;
        req_addr  = a;
        req_wdata = d;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            s = req_ready;
            @(posedge clk);
            #1;
            if (s) begin
                ok      = 1'b1;
                acc_cyc = cyc;
                model_push(rd, a, d);
                break;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic get_rsp(output logic rd, output logic [31:0] data, output logic err,
                           output bit ok);
        ok   = 1'b0;
        rd   = 1'b0;
        data = '0;
        err  = 1'b0;
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (rsp_valid) begin
                rd   = rsp_rdnwr;
                data = rsp_rdata;
                err  = rsp_err;
                ok   = 1'b1;
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
        end
        rsp_ready = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [31:0] got [10];
        logic [31:0] want[10];
        string       nm  [10];
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        got[0] = 32'(cmd_n);       want[0] = 32'd1; nm[0] = "rst_cmd_n";
        got[1] = 32'(RDnWR);       want[1] = 32'd1; nm[1] = "rst_RDnWR";
        got[2] = 32'(Addr_in);     want[2] = 32'd0; nm[2] = "rst_Addr_in";
        got[3] = 32'(Data_in_vld); want[3] = 32'd0; nm[3] = "rst_Data_in_vld";
        got[4] = Data_in;          want[4] = 32'd0; nm[4] = "rst_Data_in";
        got[5] = 32'(rsp_valid);   want[5] = 32'd0; nm[5] = "rst_rsp_valid";
        got[6] = rsp_rdata;        want[6] = 32'd0; nm[6] = "rst_rsp_rdata";
        got[7] = 32'(rsp_err);     want[7] = 32'd0; nm[7] = "rst_rsp_err";
        got[8] = 32'(rsp_rdnwr);   want[8] = 32'd0; nm[8] = "rst_rsp_rdnwr";
        got[9] = 32'(req_ready);   want[9] = 32'd0; nm[9] = "rst_req_ready";
        for (int i = 0; i < 10; i++) begin
            total++;
            if (got[i] !== want[i]) begin
                bad++;
                $display("FAIL %s: got %h want %h", nm[i], got[i], want[i]);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL post_rst_req_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic test_write();
        bit          ok, rok;
        int          acc, cl0, dv0, wv0;
        logic        rd, err;
        logic [31:0] data;
        exp_t        e;
        ctrl_delay = 7;
        cl0 = issue_cnt; dv0 = dvld_cnt; wv0 = wr_vld_cnt;
        push_req(1'b0, 16'h1234, 32'hDEADBEEF, ok, acc);
        get_rsp(rd, data, err, rok);
        total++;
        if (!ok || !rok) begin
            bad++;
            $display("FAIL wr_handshake: push_ok %b rsp_ok %b want 1 1", ok, rok);
        end else begin
            e = exp_q.pop_front();
            total++;
            if (rd !== e.rd || data !== e.data || err !== e.err) begin
                bad++;
                $display("FAIL wr_rsp: got rd=%b data=%h err=%b want rd=%b data=%h err=%b",
                         rd, data, err, e.rd, e.data, e.err);
            end
        end
        total++;
        if (last_issue_cyc !== acc + 1) begin
            bad++;
            $display("FAIL wr_issue_latency: got %0d want %0d", last_issue_cyc - acc + 1, 2);
        end
        total++;
        if (issue_cnt - cl0 !== 1) begin
            bad++;
            $display("FAIL wr_cmd_n_cycles: got %0d want 1", issue_cnt - cl0);
        end
        total++;
        if (dvld_cnt - dv0 !== 7 || wr_vld_cnt - wv0 !== 1) begin
            bad++;
            $display("FAIL wr_data_in_vld: got cycles=%0d at_write=%0d want 7 1",
                     dvld_cnt - dv0, wr_vld_cnt - wv0);
        end
        total++;
        if (last_rise_cyc !== last_issue_cyc + 8) begin
            bad++;
            $display("FAIL wr_rsp_latency: got %0d want 8", last_rise_cyc - last_issue_cyc);
        end
        total++;
        if (last_issue_addr !== 16'h1234 || unstable !== 0) begin
            bad++;
            $display("FAIL wr_addr: got addr=%h unstable=%0d want 1234 0", last_issue_addr, unstable);
        end
    endtask

    task automatic test_write_read();
        bit          ok, rok;
        int          acc;
        logic        rd, err;
        logic [31:0] data;
        exp_t        e;
        logic [15:0] a2;
        logic [31:0] d2;
        ctrl_delay = 7;
        a2 = 16'h5000 | 16'($urandom_range(0, 255));
        d2 = $urandom;
        // Rewrite 0x1234, write a random second location, then read both back.
        push_req(1'b0, 16'h1234, 32'hDEADBEEF, ok, acc);
        push_req(1'b0, a2, d2, ok, acc);
        push_req(1'b1, 16'h1234, 32'h0, ok, acc);
        push_req(1'b1, a2, 32'h0, ok, acc);
        for (int i = 0; i < 4; i++) begin
            get_rsp(rd, data, err, rok);
            total++;
            if (!rok || exp_q.size() == 0) begin
                bad++;
                $display("FAIL wrrd_rsp_%0d: got no response want response", i);
            end else begin
                e = exp_q.pop_front();
                if (rd !== e.rd || data !== e.data || err !== e.err) begin
                    bad++;
                    $display("FAIL wrrd_rsp_%0d: got rd=%b data=%h err=%b want rd=%b data=%h err=%b",
                             i, rd, data, err, e.rd, e.data, e.err);
                end
            end
            if (i == 2) begin
                total++;
                if (data !== 32'hDEADBEEF || last_issue_addr !== 16'h1234) begin
                    bad++;
                    $display("FAIL rd_1234: got data=%h addr=%h want deadbeef 1234", data, last_issue_addr);
                end
                total++;
                if (last_rise_cyc !== last_issue_cyc + 9) begin
                    bad++;
                    $display("FAIL rd_rsp_latency: got %0d want 9", last_rise_cyc - last_issue_cyc);
                end
            end
        end
        total++;
        if (unstable !== 0) begin
            bad++;
            $display("FAIL wrrd_pins_stable: got %0d changes want 0", unstable);
        end
    endtask

    task automatic test_backpressure();
        logic        rds [8];
        logic [15:0] as  [8];
        logic [31:0] ds  [8];
        int          acc, ic;
        bit          s, rok;
        logic        rd, err, s_rd, s_err;
        logic [31:0] data, s_data;
        exp_t        e;
        ctrl_delay = 3;
        rsp_ready  = 1'b0;
        for (int i = 0; i < 8; i++) begin
            rds[i] = 1'($urandom_range(0, 1));
            as[i]  = (i % 2 == 0) ? 16'h1234 : 16'(16'h0100 + i);
            ds[i]  = $urandom;
        end
        acc = 0;
        @(posedge clk);
        #1;
        for (int c = 0; c < 20; c++) begin
            req_valid = 1'b1;
            req_rdnwr = rds[acc];
            req_addr  = as[acc];
            req_wdata = ds[acc];
            @(negedge clk);
            s = req_ready;
            @(posedge clk);
            #1;
            if (s) begin
                model_push(rds[acc], as[acc], ds[acc]);
                if (acc < 7) acc++;
            end
        end
        req_valid = 1'b0;
        @(negedge clk);
        total++;
        if (acc !== 5 || req_ready !== 1'b0) begin
            bad++;
            $display("FAIL bp_accepted: got %0d req_ready=%b want 5 0", acc, req_ready);
        end
        s_rd = rsp_rdnwr; s_data = rsp_rdata; s_err = rsp_err; ic = issue_cnt;
        total++;
        if (rsp_valid !== 1'b1 || exp_q.size() == 0 || s_data !== exp_q[0].data) begin
            bad++;
            $display("FAIL bp_held_rsp: got valid=%b data=%h want valid=1 data=%h",
                     rsp_valid, s_data, (exp_q.size() != 0) ? exp_q[0].data : 32'h0);
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdnwr !== s_rd || rsp_rdata !== s_data ||
                rsp_err !== s_err || issue_cnt !== ic) begin
                bad++;
                $display("FAIL bp_stable_%0d: got v=%b rd=%b d=%h e=%b issues=%0d want 1 %b %h %b %0d",
                         c, rsp_valid, rsp_rdnwr, rsp_rdata, rsp_err, issue_cnt, s_rd, s_data, s_err, ic);
            end
        end
        for (int i = 0; i < 5; i++) begin
            get_rsp(rd, data, err, rok);
            total++;
            if (!rok || exp_q.size() == 0) begin
                bad++;
                $display("FAIL bp_drain_%0d: got no response want response", i);
            end else begin
                e = exp_q.pop_front();
                if (rd !== e.rd || data !== e.data || err !== e.err) begin
                    bad++;
                    $display("FAIL bp_drain_%0d: got rd=%b data=%h err=%b want rd=%b data=%h err=%b",
                             i, rd, data, err, e.rd, e.data, e.err);
                end
            end
        end
    endtask

    task automatic test_timeout();
        bit          ok, rok;
        int          acc;
        logic        rd, err;
        logic [31:0] data;
        exp_t        e;
        ctrl_dead = 1'b1;
        for (int i = 0; i < 2; i++) begin
            push_req((i == 0), (i == 0) ? 16'h0001 : 16'h0002, 32'hCAFE0000, ok, acc);
            get_rsp(rd, data, err, rok);
            total++;
            if (!rok || exp_q.size() == 0) begin
                bad++;
                $display("FAIL tmo_rsp_%0d: got no response want response", i);
            end else begin
                e = exp_q.pop_front();
                if (rd !== e.rd || data !== e.data || err !== e.err) begin
                    bad++;
                    $display("FAIL tmo_rsp_%0d: got rd=%b data=%h err=%b want rd=%b data=%h err=%b",
                             i, rd, data, err, e.rd, e.data, e.err);
                end
            end
            total++;
            if (last_rise_cyc - last_issue_cyc !== TIMEOUT + 2) begin
                bad++;
                $display("FAIL tmo_latency_%0d: got %0d want %0d", i,
                         last_rise_cyc - last_issue_cyc, TIMEOUT + 2);
            end
        end
        ctrl_dead = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit ok;
        int acc, ic, seen;
        ctrl_dead = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 16'(16'h0700 + i), 32'h0, ok, acc);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        ctrl_dead = 1'b0;
        @(negedge clk);
        total++;
        if (cmd_n !== 1'b1 || Data_in_vld !== 1'b0 || req_ready !== 1'b1 ||
            rsp_valid !== 1'b0 || RDnWR !== 1'b1 || Addr_in !== 16'h0) begin
            bad++;
            $display("FAIL mid_rst_pins: got cmd_n=%b vld=%b rdy=%b rsp_v=%b RDnWR=%b addr=%h want 1 0 1 0 1 0000",
                     cmd_n, Data_in_vld, req_ready, rsp_valid, RDnWR, Addr_in);
        end
        ic   = issue_cnt;
        seen = 0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        rsp_ready = 1'b0;
        total++;
        if (seen !== 0 || issue_cnt !== ic) begin
            bad++;
            $display("FAIL mid_rst_drop: got rsp_cycles=%0d new_issues=%0d want 0 0", seen, issue_cnt - ic);
        end
    endtask

    task automatic test_random();
        localparam int N = 24;
        int got_n;
        ctrl_rand = 1'b1;
        got_n     = 0;
        fork
            begin : producer
                bit          ok;
                int          acc;
                logic [15:0] pool [4];
                pool[0] = 16'h1234; pool[1] = 16'h0040; pool[2] = 16'h8001; pool[3] = 16'hFFFF;
                for (int n = 0; n < N; n++) begin
                    repeat ($urandom_range(0, 3)) @(posedge clk);
                    push_req(1'($urandom_range(0, 1)), pool[$urandom_range(0, 3)], $urandom, ok, acc);
                end
            end
            begin : consumer
                exp_t e;
                for (int c = 0; c < 3000 && got_n < N; c++) begin
                    @(posedge clk);
                    #1;
                    rsp_ready = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    if (rsp_valid && rsp_ready) begin
                        got_n++;
                        total++;
                        if (exp_q.size() == 0) begin
                            bad++;
                            $display("FAIL rand_rsp_%0d: got unexpected response want none", got_n);
                        end else begin
                            e = exp_q.pop_front();
                            if (rsp_rdnwr !== e.rd || rsp_rdata !== e.data || rsp_err !== e.err) begin
                                bad++;
                                $display("FAIL rand_rsp_%0d: got rd=%b data=%h err=%b want rd=%b data=%h err=%b",
                                         got_n, rsp_rdnwr, rsp_rdata, rsp_err, e.rd, e.data, e.err);
                            end
                        end
                    end
                end
                @(posedge clk);
                #1;
                rsp_ready = 1'b0;
            end
        join
        ctrl_rand = 1'b0;
        total++;
        if (got_n !== N || unstable !== 0) begin
            bad++;
            $display("FAIL rand_count: got %0d responses unstable=%0d want %0d 0", got_n, unstable, N);
        end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_rdnwr = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_write();
        test_write_read();
        test_backpressure();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
